// File: rtl/usbdev_line_monitor_if.sv
// usbdev line monitor bus bundle: D+/D-/OE toward the monitor,
// tick, decoded line state and J/idle detect levels back out.
interface usbdev_line_monitor_if;
   logic       usb_dp_i;
   logic       usb_dn_i;
   logic       usb_oe_i;
   logic       us_tick_o;
   logic [1:0] line_state_o;
   logic       rx_j_det_o;
   logic       rx_idle_det_o;

   modport master (
      output usb_dp_i,
      output usb_dn_i,
      output usb_oe_i,
      input  us_tick_o,
      input  line_state_o,
      input  rx_j_det_o,
      input  rx_idle_det_o
   );

   modport slave (
      input  usb_dp_i,
      input  usb_dn_i,
      input  usb_oe_i,
      output us_tick_o,
      output line_state_o,
      output rx_j_det_o,
      output rx_idle_det_o
   );
endinterface

// File: rtl/usbdev_line_monitor.sv
// usbdev line monitor: 1 us tick, FS line decode, J / idle detect.
// Define USBDEV_LINEMON_SYNC_EN to add a 2-flop pin synchronizer.
module usbdev_line_monitor #(
   parameter int CLK_PER_US  = 48,
   parameter int J_CYCLES    = 3,
   parameter int IDLE_CYCLES = 32
) (
   input  logic                 clk_48mhz_i,
   input  logic                 rst_i,
   usbdev_line_monitor_if.slave bus
);

   localparam int TW = $clog2(CLK_PER_US);
   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_US - 1);
   localparam logic [8:0] J_RUN    = 9'(J_CYCLES);
   localparam logic [8:0] IDLE_RUN = 9'(IDLE_CYCLES);
   localparam logic [1:0] LINE_J   = 2'b01;

   typedef enum logic [1:0] {
      ST_BUSY  = 2'd0,
      ST_JSEEN = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   state_t        state_q;
   logic [TW-1:0] tick_cnt_q;
   logic          tick_q;
   logic [1:0]    line_q;
   logic [7:0]    run_cnt_q;
   logic          j_det_q;
   logic          idle_det_q;
   logic [1:0]    line_raw;
   logic          sample_j;
   logic [8:0]    run_inc;

`ifdef USBDEV_LINEMON_SYNC_EN
   logic [1:0] sync1_q;
   logic [1:0] sync2_q;

   // Two-flop synchronizer, parked at J so reset looks like an idle bus
   always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= LINE_J;
         sync2_q <= LINE_J;
      end else begin
         sync1_q <= {bus.usb_dn_i, bus.usb_dp_i};
         sync2_q <= sync1_q;
      end
   end

   assign line_raw = sync2_q;
`else
   assign line_raw = {bus.usb_dn_i, bus.usb_dp_i};
`endif

   assign sample_j = (line_raw == LINE_J) & ~bus.usb_oe_i;
   assign run_inc  = {1'b0, run_cnt_q} + 9'd1;

   // Free-running microsecond divider with registered pulse
   always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
      if (rst_i) begin
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         tick_q <= (tick_cnt_q == TICK_LAST);
         if (tick_cnt_q == TICK_LAST) tick_cnt_q <= '0;
         else tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   // Registered line decode; {dn,dp} already is the state code
   always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
      if (rst_i) line_q <= 2'd0;
      else line_q <= line_raw;
   end

   // Saturating length of the current J run
   always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
      if (rst_i) run_cnt_q <= '0;
      else if (!sample_j) run_cnt_q <= '0;
      else if (run_cnt_q != 8'hff) run_cnt_q <= run_cnt_q + 8'd1;
   end

   // Link FSM; detect levels follow the state one cycle later
   always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_BUSY;
         j_det_q    <= 1'b0;
         idle_det_q <= 1'b0;
      end else begin
         j_det_q    <= (state_q == ST_JSEEN) | (state_q == ST_IDLE);
         idle_det_q <= (state_q == ST_IDLE);
         case (state_q)
            ST_BUSY: begin
               if (sample_j && run_inc == J_RUN) state_q <= ST_JSEEN;
            end
            ST_JSEEN: begin
               if (!sample_j) state_q <= ST_BUSY;
               else if (run_inc == IDLE_RUN) state_q <= ST_IDLE;
            end
            ST_IDLE: begin
               if (!sample_j) state_q <= ST_BUSY;
            end
            default: state_q <= ST_BUSY;
         endcase
      end
   end

   assign bus.us_tick_o     = tick_q;
   assign bus.line_state_o  = line_q;
   assign bus.rx_j_det_o    = j_det_q;
   assign bus.rx_idle_det_o = idle_det_q;

endmodule

// File: tb/tb_usbdev_line_monitor.sv
// Bench for usbdev_line_monitor: run-length model plus directed
// scenarios with hand-computed event cycles.
module tb_usbdev_line_monitor;

   localparam int CPU  = 48;
   localparam int JC   = 3;
   localparam int IC   = 32;
`ifdef USBDEV_LINEMON_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   started = 1'b0;

   usbdev_line_monitor_if bus ();

   usbdev_line_monitor #(
      .CLK_PER_US (CPU),
      .J_CYCLES   (JC),
      .IDLE_CYCLES(IC)
   ) dut (
      .clk_48mhz_i(clk),
      .rst_i      (rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                    nm, act, exp, $time);
   endtask

   // Model: outputs follow from the length of the J run seen so far
   int         t;
   int         run;
   logic       exp_tick, exp_j, exp_idle;
   logic [1:0] exp_line;
   logic [1:0] pin_now, seen;
   logic [1:0] h0, h1;
   logic       isj;

   assign pin_now = {bus.usb_dn_i, bus.usb_dp_i};
`ifdef USBDEV_LINEMON_SYNC_EN
   assign seen = h1;
`else
   assign seen = pin_now;
`endif
   assign isj = (seen == 2'b01) && !bus.usb_oe_i;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t        <= 0;
         run      <= 0;
         exp_tick <= 1'b0;
         exp_j    <= 1'b0;
         exp_idle <= 1'b0;
         exp_line <= 2'd0;
         h0       <= 2'b01;
         h1       <= 2'b01;
      end else begin
         t        <= t + 1;
         exp_tick <= ((t + 1) % CPU) == 0;
         exp_line <= seen;
         exp_j    <= run >= JC;
         exp_idle <= run >= IC;
         run      <= isj ? run + 1 : 0;
         h0       <= pin_now;
         h1       <= h0;
      end
   end

   // Event recorder and per-cycle compare against the model
   int   j_rise, j_fall, i_rise, i_fall;
   int   i_fall_cnt = 0;
   int   se0_cnt = 0;
   int   oe_hi = 0;
   int   hold_lo = 0;
   int   line_c1 = -1;
   int   ticks[$];
   bit   oe_win = 1'b0;
   bit   hold_win = 1'b0;
   logic j_prev = 1'b0;
   logic i_prev = 1'b0;

   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("tick", int'(bus.us_tick_o), int'(exp_tick));
         chk("line", int'(bus.line_state_o), int'(exp_line));
         chk("jdet", int'(bus.rx_j_det_o), int'(exp_j));
         chk("idle", int'(bus.rx_idle_det_o), int'(exp_idle));
         if (!rst) begin
            if (bus.rx_j_det_o && !j_prev) j_rise = t;
            if (!bus.rx_j_det_o && j_prev) j_fall = t;
            if (bus.rx_idle_det_o && !i_prev) i_rise = t;
            if (!bus.rx_idle_det_o && i_prev) begin
               i_fall = t;
               i_fall_cnt++;
            end
            if (bus.us_tick_o) ticks.push_back(t);
            if (bus.line_state_o == 2'd0) se0_cnt++;
            if (t == 1) line_c1 = int'(bus.line_state_o);
            if (oe_win && (bus.rx_j_det_o || bus.rx_idle_det_o))
               oe_hi++;
            if (hold_win && !bus.rx_idle_det_o) hold_lo++;
         end
         j_prev = bus.rx_j_det_o;
         i_prev = bus.rx_idle_det_o;
      end
   end

   task automatic pins(input logic dp, input logic dn,
                       input logic oe);
      bus.usb_dp_i = dp;
      bus.usb_dn_i = dn;
      bus.usb_oe_i = oe;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int k0, p0, e0, o0, o1, s0, c0, base;

   initial begin
      pins(1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      started = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_tick", int'(bus.us_tick_o), 0);
      chk("rst_line", int'(bus.line_state_o), 0);
      chk("rst_jdet", int'(bus.rx_j_det_o), 0);
      chk("rst_idle", int'(bus.rx_idle_det_o), 0);
      rst = 1'b0;

      // J from cycle 0, 200 cycles
      step(200);
      chk("c1_line", line_c1, 1);
      chk("j_rise0", j_rise, JC + 1);
      chk("i_rise0", i_rise, IC + 1);
      chk("n_ticks", ticks.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("tick_at", ticks[i], CPU * (i + 1));

      // One K cycle while idle
      k0 = t;
      pins(1'b0, 1'b1, 1'b0);
      step(1);
      pins(1'b1, 1'b0, 1'b0);
      step(60);
      chk("k_jfall", j_fall, k0 + 2 + SD);
      chk("k_ifall", i_fall, k0 + 2 + SD);
      chk("k_jrise", j_rise, k0 + 5 + SD);
      chk("k_irise", i_rise, k0 + 34 + SD);

      // Packet: J/K toggles, SE0 EOP, then J
      p0 = t;
      base = se0_cnt;
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) pins(1'b0, 1'b1, 1'b0);
         else pins(1'b1, 1'b0, 1'b0);
         step(1);
      end
      pins(1'b0, 1'b0, 1'b0);
      step(8);
      e0 = t;
      pins(1'b1, 1'b0, 1'b0);
      step(50);
      chk("p_ifall", i_fall, p0 + 2 + SD);
      chk("eop_len", se0_cnt - base, 8);
      chk("p_jrise", j_rise, e0 + 4 + SD);
      chk("p_irise", i_rise, e0 + 33 + SD);

      // J while the device drives the bus
      o0 = t;
      pins(1'b1, 1'b0, 1'b1);
      step(2);
      oe_win = 1'b1;
      step(48);
      oe_win = 1'b0;
      chk("oe_ifall", i_fall, o0 + 2);
      chk("oe_quiet", oe_hi, 0);
      o1 = t;
      pins(1'b1, 1'b0, 1'b0);
      step(40);
      chk("oe_jrise", j_rise, o1 + 4);
      chk("oe_irise", i_rise, o1 + 33);

      // Long J hold past counter saturation
      hold_win = 1'b1;
      step(1000);
      hold_win = 1'b0;
      chk("sat_hold", hold_lo, 0);

      // SE1 is not J
      s0 = t;
      pins(1'b1, 1'b1, 1'b0);
      step(1);
      pins(1'b1, 1'b0, 1'b0);
      step(40);
      chk("se1_jfall", j_fall, s0 + 2 + SD);
      chk("se1_jrise", j_rise, s0 + 5 + SD);

      // OE rise and K together: a single drop
      c0 = t;
      base = i_fall_cnt;
      pins(1'b0, 1'b1, 1'b1);
      step(1);
      pins(1'b1, 1'b0, 1'b0);
      step(40);
      chk("ok_ifall", i_fall, c0 + 2);
      chk("ok_nfall", i_fall_cnt - base, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
